// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores,
// with bounded hold time and per-core registered read-data return.
module mem_arbiter_rr #(
    parameter int NCORES   = 3,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RAM_LAT  = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    rden,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [NCORES*DW-1:0] Din,
    input  logic [DW-1:0]        RAMq,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES*DW-1:0] Dq,
    output logic [NCORES-1:0]    rvalid,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT = '1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt, last, pick;
    logic [HW-1:0]       hold_cnt, hold_nxt;
    logic [NCORES-1:0]   req, g_onehot;
    logic                others, found, hold_ok;
    logic                g_rden, g_wren, push_vld;
    logic [AW-1:0]       g_addr;
    logic [DW-1:0]       g_din;
    int                  base, c;
    logic [RAM_LAT-1:0]          tag_vld;
    logic [RAM_LAT-1:0][IW-1:0]  tag_core;

    assign req = rden | wren;

    always_comb begin
        others = 1'b0;
        for (int i = 0; i < NCORES; i++)
            if (req[i] && IW'(i) != owner) others = 1'b1;

        // Rotating scan: from the owner when busy (owner itself excluded), from last when idle.
        found = 1'b0;
        pick  = '0;
        c     = 0;
        base  = (state == S_GRANT) ? int'(owner) : int'(last);
        for (int k = 1; k <= NCORES; k++) begin
            c = (base + k) % NCORES;
            if (!found && req[c] && (state == S_IDLE || k < NCORES)) begin
                found = 1'b1;
                pick  = IW'(c);
            end
        end

        hold_ok   = (MAX_HOLD == 0) || (hold_cnt < HOLD_MAX) || !others;
        state_nxt = S_IDLE;
        owner_nxt = owner;
        hold_nxt  = '0;
        if (state == S_GRANT && req[owner] && hold_ok) begin
            state_nxt = S_GRANT;
            hold_nxt  = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
        end else if (found) begin
            state_nxt = S_GRANT;
            owner_nxt = pick;
            hold_nxt  = HW'(1);
        end

        g_onehot = '0;
        g_addr   = '0;
        g_din    = '0;
        g_rden   = 1'b0;
        g_wren   = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (owner_nxt == IW'(i)) begin
                g_onehot[i] = 1'b1;
                g_addr      = Address[i*AW +: AW];
                g_din       = Din[i*DW +: DW];
                g_rden      = rden[i];
                g_wren      = wren[i];
            end
        end
        // A write wins over a simultaneous read, so no read tag is issued.
        push_vld = (state_nxt == S_GRANT) && g_rden && !g_wren;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= '0;
            last       <= IW'(NCORES - 1);
            hold_cnt   <= '0;
            acq        <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
            tag_vld    <= '0;
            tag_core   <= '0;
            Dq         <= '0;
            rvalid     <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            if (state_nxt == S_GRANT) begin
                acq        <= g_onehot;
                RAMAddress <= g_addr;
                RAMDin     <= g_din;
                RAMwren    <= g_wren;
                last       <= owner_nxt;
            end else begin
                acq     <= '0;
                RAMwren <= 1'b0;
            end

            for (int s = RAM_LAT - 1; s > 0; s--) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_core[s] <= tag_core[s-1];
            end
            tag_vld[0]  <= push_vld;
            tag_core[0] <= owner_nxt;

            for (int i = 0; i < NCORES; i++) begin
                rvalid[i] <= 1'b0;
                if (tag_vld[RAM_LAT-1] && tag_core[RAM_LAT-1] == IW'(i)) begin
                    Dq[i*DW +: DW] <= RAMq;
                    rvalid[i]      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model.
module tb_mem_arbiter_rr;
    localparam int N = 3, AW = 8, DW = 8, RL = 2, MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    rden, wren, acq, rvalid;
    logic [N*AW-1:0] Address;
    logic [N*DW-1:0] Din, Dq;
    logic [DW-1:0]   RAMq, RAMDin;
    logic [AW-1:0]   RAMAddress;
    logic            RAMwren;

    logic [N-1:0]    u_rden, u_wren, u_acq, u_rvalid;
    logic [N*AW-1:0] u_Address;
    logic [N*DW-1:0] u_Din, u_Dq;
    logic [DW-1:0]   u_RAMDin;
    logic [AW-1:0]   u_RAMAddress;
    logic            u_RAMwren;

    mem_arbiter_rr #(.NCORES(N), .AW(AW), .DW(DW), .RAM_LAT(RL), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
        .RAMq(RAMq), .acq(acq), .Dq(Dq), .rvalid(rvalid), .RAMAddress(RAMAddress),
        .RAMDin(RAMDin), .RAMwren(RAMwren));

    mem_arbiter_rr #(.NCORES(N), .AW(AW), .DW(DW), .RAM_LAT(RL), .MAX_HOLD(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .rden(u_rden), .wren(u_wren), .Address(u_Address), .Din(u_Din),
        .RAMq(8'h00), .acq(u_acq), .Dq(u_Dq), .rvalid(u_rvalid), .RAMAddress(u_RAMAddress),
        .RAMDin(u_RAMDin), .RAMwren(u_RAMwren));

    always #5 clk = ~clk;

    // Read-only RAM contents with a one-register read path (RAM_LAT = 2 with the address register).
    logic [DW-1:0] rom [256];
    always @(posedge clk) RAMq <= rom[RAMAddress];

    int n_chk = 0, n_pass = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: grant owner as an int (-1 = idle) and a queue of pending read returns.
    typedef struct {int core; logic [DW-1:0] data;} ret_t;
    ret_t            rq[$];
    int              m_owner, m_hold, m_last;
    logic [N-1:0]    e_acq, e_rvalid;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_din;
    logic            e_wren;
    logic [N*DW-1:0] e_dq;

    task automatic model_reset();
        m_owner = -1; m_hold = 0; m_last = N - 1;
        e_acq = '0; e_rvalid = '0; e_addr = '0; e_din = '0; e_wren = 1'b0; e_dq = '0;
        rq.delete();
    endtask

    task automatic model_edge();
        int g, base, span, cand;
        bit others;
        ret_t r;
        if (!rst_n) return;
        g = -1;
        others = 0;
        for (int i = 0; i < N; i++) if (i != m_owner && (rden[i] | wren[i])) others = 1;
        if (m_owner >= 0 && (rden[m_owner] | wren[m_owner]) && (MH == 0 || m_hold < MH || !others)) begin
            g = m_owner;
            if (m_hold < MH) m_hold++;
        end else begin
            base = (m_owner >= 0) ? m_owner : m_last;
            span = (m_owner >= 0) ? N - 1 : N;
            for (int k = 1; k <= span; k++) begin
                cand = (base + k) % N;
                if (g < 0 && (rden[cand] | wren[cand])) g = cand;
            end
            m_hold = (g >= 0) ? 1 : 0;
        end
        e_rvalid = '0;
        if (rq.size() == RL) begin
            r = rq.pop_front();
            if (r.core >= 0) begin
                e_rvalid[r.core] = 1'b1;
                e_dq[r.core*DW +: DW] = r.data;
            end
        end
        r.core = -1;
        r.data = '0;
        m_owner = g;
        if (g >= 0) begin
            e_acq = '0;
            e_acq[g] = 1'b1;
            e_addr = Address[g*AW +: AW];
            e_din  = Din[g*DW +: DW];
            e_wren = wren[g];
            m_last = g;
            if (rden[g] && !wren[g]) begin
                r.core = g;
                r.data = rom[e_addr];
            end
        end else begin
            e_acq = '0;
            e_wren = 1'b0;
        end
        rq.push_back(r);
    endtask

    task automatic check_outputs();
        chk("acq", acq, e_acq);
        chk("RAMAddress", RAMAddress, e_addr);
        chk("RAMDin", RAMDin, e_din);
        chk("RAMwren", RAMwren, e_wren);
        chk("rvalid", rvalid, e_rvalid);
        chk("Dq", Dq, e_dq);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    int rem[N];
    int wait_cnt[N];
    int max_wait, kind;
    logic [2:0] exp_g;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
        rom[8'h2A] = 8'h5C;
        rden = '0; wren = '0; Address = '0; Din = '0;
        u_rden = '0; u_wren = '0; u_Address = '0; u_Din = '0;
        model_reset();
        #2;
        do_reset();

        // Single read by core 1.
        Address[15:8] = 8'h2A;
        rden[1] = 1'b1;
        tick();
        chk("t1_acq", acq, 3'b010);
        chk("t1_addr", RAMAddress, 8'h2A);
        rden[1] = 1'b0;
        tick();
        chk("t1_rvalid_early", rvalid, 3'b000);
        tick();
        chk("t1_rvalid", rvalid, 3'b010);
        chk("t1_dq", Dq[15:8], 8'h5C);
        tick();
        chk("t1_rvalid_len", rvalid, 3'b000);
        chk("t1_dq_hold", Dq[15:8], 8'h5C);

        // Three continuous requesters rotate in blocks of MAX_HOLD.
        do_reset();
        Address = {8'h03, 8'h02, 8'h01};
        rden = 3'b111;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_g = 3'(1 << ((k / 4) % 3));
            chk("t2_grant", acq, exp_g);
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] = acq[i] ? 0 : wait_cnt[i] + 1;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        chk("t2_wait_bound", (max_wait <= (N - 1) * MH), 1'b1);
        rden = '0;
        tick();
        chk("t3_idle", acq, 3'b000);

        // Owner drops while another waits: handover on the same edge.
        Address[23:16] = 8'h44;
        rden[2] = 1'b1;
        tick();
        chk("t3_grant2", acq, 3'b100);
        tick();
        Address[7:0] = 8'h07;
        rden[0] = 1'b1;
        tick();
        chk("t3_hold", acq, 3'b100);
        rden[2] = 1'b0;
        tick();
        chk("t3_switch", acq, 3'b001);
        rden = '0;
        for (int k = 0; k < 4; k++) tick();

        // Simultaneous read and write: write only.
        Address[7:0] = 8'h10;
        Din[7:0] = 8'hA5;
        rden[0] = 1'b1;
        wren[0] = 1'b1;
        tick();
        chk("t4_acq", acq, 3'b001);
        chk("t4_wren", RAMwren, 1'b1);
        chk("t4_din", RAMDin, 8'hA5);
        chk("t4_addr", RAMAddress, 8'h10);
        rden = '0;
        wren = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_no_rvalid", rvalid, 3'b000);
        end

        // Reset in the middle of a read.
        Address[15:8] = 8'h33;
        rden[1] = 1'b1;
        tick();
        chk("t5_acq", acq, 3'b010);
        rden[1] = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_acq", acq, 3'b000);
        chk("t5_rst_rvalid", rvalid, 3'b000);
        chk("t5_rst_wren", RAMwren, 1'b0);
        chk("t5_rst_addr", RAMAddress, 8'h00);
        chk("t5_rst_din", RAMDin, 8'h00);
        chk("t5_rst_dq", Dq, 24'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_no_rvalid", rvalid, 3'b000);
        end

        // Unlimited hold on the second instance.
        u_rden = 3'b011;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t6_hold0", u_acq, 3'b001);
        end
        u_rden[0] = 1'b0;
        tick();
        chk("t6_switch", u_acq, 3'b010);
        u_rden = '0;
        tick();

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        rden[i] = 1'b0;
                        wren[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 3);
                    rden[i] = (kind != 1);
                    wren[i] = (kind == 1 || kind == 2);
                    Address[i*AW +: AW] = AW'($urandom);
                    Din[i*DW +: DW] = DW'($urandom);
                    rem[i] = $urandom_range(1, 8);
                end
            end
            if (k == 700) do_reset();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
